// File: rtl/w100_stim_gen.sv
// Self-checking stimulus source for w100: LFSR-driven G0..G3, golden G10 compare, start/done handshake.
// Optional first-failure log enabled by defining W100_STIM_ERRLOG_EN.
module w100_stim_gen #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             G0,
  output logic             G1,
  output logic             G2,
  output logic             G3,
  input  logic             G10,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_index
`ifdef W100_STIM_ERRLOG_EN
  ,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [4:0]       first_fail_vec
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_nxt;
  logic             g3_d;
  logic             exp_g10;
  logic             mismatch;
  logic             last_vec;
  logic [CNT_W-1:0] err_nxt;

  // g3_d shadows w100's internal G7 register so the golden compare is cycle-exact.
  always_comb begin
    lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    exp_g10  = g3_d & ~(G1 ? G0 : G2);
    mismatch = (G10 != exp_g10);
    last_vec = (vec_index == LAST_IDX);
    err_nxt  = err_count;
    if (mismatch && (err_count != '1)) begin
      err_nxt = err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      lfsr      <= LFSR_SEED;
      G0        <= 1'b0;
      G1        <= 1'b0;
      G2        <= 1'b0;
      G3        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_index <= '0;
      g3_d      <= 1'b0;
`ifdef W100_STIM_ERRLOG_EN
      first_fail_idx <= '0;
      first_fail_vec <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            lfsr      <= LFSR_SEED;
            {G3, G2, G1, G0} <= LFSR_SEED[3:0];
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_index <= '0;
            g3_d      <= 1'b0;
`ifdef W100_STIM_ERRLOG_EN
            first_fail_idx <= '0;
            first_fail_vec <= '0;
`endif
          end
        end
        S_RUN: begin
          err_count <= err_nxt;
          g3_d      <= G3;
          lfsr      <= lfsr_nxt;
`ifdef W100_STIM_ERRLOG_EN
          if (mismatch && (err_count == '0)) begin
            first_fail_idx <= vec_index;
            first_fail_vec <= {G10, G3, G2, G1, G0};
          end
`endif
          if (last_vec) begin
            // Final compare is folded into pass via err_nxt; vec_index stays on the last vector.
            state <= S_DONE;
            {G3, G2, G1, G0} <= 4'h0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            {G3, G2, G1, G0} <= lfsr_nxt[3:0];
            vec_index <= vec_index + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w100_stim_gen.sv
// Directed bench for w100_stim_gen: behavioural w100 responder, tied-off G10 cases, restart and reset handling.
module tb_w100_stim_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;

  // Instance A: default 64-vector run against a w100 model or a tied G10.
  logic        start_a;
  logic        g0a, g1a, g2a, g3a, g10a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] err_a, vidx_a;
  logic [1:0]  mode_a;   // 0: w100 model, 1: tied 1, 2: tied 0
  logic        g7;

  // Instance B: single-vector run. Instance C: 3-bit counters for saturation.
  logic        start_b, g10_b;
  logic        g0b, g1b, g2b, g3b, busy_b, done_b, pass_b;
  logic [15:0] err_b, vidx_b;
  logic        start_c;
  logic        g0c, g1c, g2c, g3c, busy_c, done_c, pass_c;
  logic [2:0]  err_c, vidx_c;

`ifdef W100_STIM_ERRLOG_EN
  logic [15:0] ffi_a, ffi_b;
  logic [4:0]  ffv_a, ffv_b, ffv_c;
  logic [2:0]  ffi_c;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) g7 <= 1'b0;
    else          g7 <= g3a;
  end
  assign g10a = (mode_a == 2'd0) ? (g7 & ~(g1a ? g0a : g2a)) : (mode_a == 2'd1);

  w100_stim_gen #(.NUM_VECTORS(64), .LFSR_SEED(8'hA5), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .G0(g0a), .G1(g1a), .G2(g2a), .G3(g3a), .G10(g10a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .vec_index(vidx_a)
`ifdef W100_STIM_ERRLOG_EN
    , .first_fail_idx(ffi_a), .first_fail_vec(ffv_a)
`endif
  );

  w100_stim_gen #(.NUM_VECTORS(1), .LFSR_SEED(8'hA5), .CNT_W(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .G0(g0b), .G1(g1b), .G2(g2b), .G3(g3b), .G10(g10_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .vec_index(vidx_b)
`ifdef W100_STIM_ERRLOG_EN
    , .first_fail_idx(ffi_b), .first_fail_vec(ffv_b)
`endif
  );

  w100_stim_gen #(.NUM_VECTORS(8), .LFSR_SEED(8'hA5), .CNT_W(3)) dut_c (
    .clock(clock), .reset_n(reset_n), .start(start_c),
    .G0(g0c), .G1(g1c), .G2(g2c), .G3(g3c), .G10(1'b1),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .vec_index(vidx_c)
`ifdef W100_STIM_ERRLOG_EN
    , .first_fail_idx(ffi_c), .first_fail_vec(ffv_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Number of vectors in a seed-A5 run whose golden G10 is 1.
  function automatic int count_exp1(input int n);
    logic [7:0] q;
    logic       g3d;
    int         c;
    q   = 8'hA5;
    g3d = 1'b0;
    c   = 0;
    for (int i = 0; i < n; i++) begin
      if (g3d & ~(q[1] ? q[0] : q[2])) c++;
      g3d = q[3];
      q   = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
    return c;
  endfunction

  // Pulse (or hold) start on A, check every driven vector, end at the first negedge in DONE.
  task automatic run_a(input bit hold);
    logic [7:0] m;
    m = 8'hA5;
    start_a = 1'b1;
    @(negedge clock);
    if (!hold) start_a = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk("run_busy", busy_a, 1);
      chk("run_vidx", vidx_a, i);
      chk("run_gvec", {g3a, g2a, g1a, g0a}, m[3:0]);
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      @(negedge clock);
    end
    chk("end_done", done_a, 1);
    chk("end_busy", busy_a, 0);
    chk("end_vidx", vidx_a, 63);
    chk("end_gvec", {g3a, g2a, g1a, g0a}, 0);
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_err"}, err_a, 0);
    chk({tag, "_vidx"}, vidx_a, 0);
    chk({tag, "_gvec"}, {g3a, g2a, g1a, g0a}, 0);
  endtask

  initial begin
    int stuck_err;
    stuck_err = 64 - count_exp1(64);
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    g10_b   = 1'b1;
    mode_a  = 2'd0;

    // Reset state, then one idle clock after release.
    #12;
    chk_a_reset("rst");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk_a_reset("idle");

    // Golden run against the w100 model.
    run_a(1'b0);
    chk("gold_err", err_a, 0);
    chk("gold_pass", pass_a, 1);
    @(negedge clock);
    chk("gold_hold_done", done_a, 1);
    chk("gold_hold_vidx", vidx_a, 63);

    // Stuck-at-1 G10 with start held through the run.
    mode_a = 2'd1;
    run_a(1'b1);
    chk("stuck_err", err_a, stuck_err);
    chk("stuck_pass", pass_a, 0);
`ifdef W100_STIM_ERRLOG_EN
    chk("stuck_ffi", ffi_a, 0);
    chk("stuck_ffv", ffv_a, 5'b10101);
`endif
    @(negedge clock);
    chk("restart_busy", busy_a, 1);
    chk("restart_done", done_a, 0);
    chk("restart_err", err_a, 0);
    chk("restart_vidx", vidx_a, 0);
    chk("restart_gvec", {g3a, g2a, g1a, g0a}, 4'h5);
`ifdef W100_STIM_ERRLOG_EN
    chk("restart_ffv", ffv_a, 0);
`endif
    start_a = 1'b0;

    // Mid-run reset at vector 10.
    for (int k = 0; k < 20 && vidx_a != 16'd10; k++) @(negedge clock);
    chk("mid_vidx", vidx_a, 10);
    chk("mid_err_nonzero", (err_a != 16'd0), 1);
    #2 reset_n = 1'b0;
    #1 chk_a_reset("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    mode_a  = 2'd0;
    @(negedge clock);
    run_a(1'b0);
    chk("post_err", err_a, 0);
    chk("post_pass", pass_a, 1);

    // Single-vector instance, G10 tied 1 then 0.
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    chk("one_busy", busy_b, 1);
    chk("one_gvec", {g3b, g2b, g1b, g0b}, 4'h5);
    @(negedge clock);
    chk("one_done", done_b, 1);
    chk("one_err1", err_b, 1);
    chk("one_pass1", pass_b, 0);
    chk("one_vidx", vidx_b, 0);
    g10_b   = 1'b0;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    @(negedge clock);
    chk("one_err0", err_b, 0);
    chk("one_pass0", pass_b, 1);

    // Saturation: all eight seed-A5 vectors expect 0, so tied-1 G10 misses 8 times.
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    repeat (8) @(negedge clock);
    chk("sat_done", done_c, 1);
    chk("sat_err", err_c, 3'b111);
    chk("sat_pass", pass_c, 0);
    chk("sat_vidx", vidx_c, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
